// File: rtl/bounce_motion_ctrl.sv
// Bouncing-square motion controller: frame-divided, two-cycle shared-ALU axis update.
// Optional BOUNCE_CNT_EN adds a saturating bounce counter output.
module bounce_motion_ctrl #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CORDW = 10,
  parameter int X0    = 220,
  parameter int Y0    = 140,
  parameter int SIZE0 = 200,
  parameter int SPD0  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [1:0]       i_cfg_addr,
  input  logic [CORDW-1:0] i_cfg_data,
  output logic [CORDW-1:0] o_qx,
  output logic [CORDW-1:0] o_qy,
  output logic [CORDW-1:0] o_qsize,
  output logic             o_qdx,
  output logic             o_qdy,
  output logic             o_bounce,
  output logic             o_busy
`ifdef BOUNCE_CNT_EN
  ,
  output logic [15:0]      o_bounce_cnt
`endif
);

  localparam int W = CORDW + 2;
  localparam logic [W-1:0] HL1 = W'(H_RES - 1);
  localparam logic [W-1:0] VL1 = W'(V_RES - 1);
  localparam logic [CORDW-1:0] SZ_LIM = CORDW'(V_RES - 1);
  localparam logic [CORDW-1:0] SZ_MAX = CORDW'(V_RES - 2);

  typedef enum logic [1:0] {IDLE, WAIT, UPD_X, UPD_Y} state_t;

  state_t state, nxt;

  logic [CORDW-1:0] spdx, spdy, sh_spdx, sh_spdy, sh_size;
  logic [7:0]       div, sh_div, fcnt;
  logic             step_q, hit_x, frm_ok, cfg_acc, sel_y;

  logic [W-1:0] a_pos, a_spd, a_size, a_lim1, a_new;
  logic         a_dir, a_ndir, a_hit;

  assign o_busy      = (state == UPD_X) || (state == UPD_Y);
  assign o_cfg_ready = !o_busy;
  assign cfg_acc     = i_cfg_valid && o_cfg_ready;
  assign frm_ok      = (state == WAIT) && i_frame && (fcnt == div - 8'd1);
  assign sel_y       = (state == UPD_Y);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (i_run || i_step) nxt = WAIT;
      WAIT: begin
        if (frm_ok)                          nxt = UPD_X;
        else if (!i_run && !step_q && !i_step) nxt = IDLE;
      end
      UPD_X: nxt = UPD_Y;
      UPD_Y: nxt = i_run ? WAIT : IDLE;
    endcase
  end

  // One adder/comparator shared by both axes, selected by state
  always_comb begin
    a_pos  = sel_y ? {2'b00, o_qy} : {2'b00, o_qx};
    a_spd  = sel_y ? {2'b00, spdy} : {2'b00, spdx};
    a_dir  = sel_y ? o_qdy : o_qdx;
    a_lim1 = sel_y ? VL1 : HL1;
    a_size = {2'b00, o_qsize};
    a_new  = a_pos;
    a_ndir = a_dir;
    a_hit  = 1'b0;
    if (!a_dir) begin
      if (a_pos + a_size + a_spd >= a_lim1) begin
        a_new  = a_lim1 - a_size;
        a_ndir = 1'b1;
        a_hit  = 1'b1;
      end else begin
        a_new = a_pos + a_spd;
      end
    end else begin
      if (a_pos < a_spd) begin
        a_new  = '0;
        a_ndir = 1'b0;
        a_hit  = 1'b1;
      end else begin
        a_new = a_pos - a_spd;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_qx     <= CORDW'(X0);
      o_qy     <= CORDW'(Y0);
      o_qsize  <= CORDW'(SIZE0);
      o_qdx    <= 1'b0;
      o_qdy    <= 1'b0;
      o_bounce <= 1'b0;
      spdx     <= CORDW'(SPD0);
      spdy     <= CORDW'(SPD0);
      div      <= 8'd1;
      sh_spdx  <= CORDW'(SPD0);
      sh_spdy  <= CORDW'(SPD0);
      sh_size  <= CORDW'(SIZE0);
      sh_div   <= 8'd1;
      fcnt     <= 8'd0;
      step_q   <= 1'b0;
      hit_x    <= 1'b0;
    end else begin
      o_bounce <= 1'b0;
      if (cfg_acc) begin
        unique case (i_cfg_addr)
          2'd0: sh_spdx <= i_cfg_data;
          2'd1: sh_spdy <= i_cfg_data;
          2'd2: sh_size <= (i_cfg_data >= SZ_LIM) ? SZ_MAX : i_cfg_data;
          2'd3: begin
`ifdef BOUNCE_CNT_EN
            if (!i_cfg_data[CORDW-1])
`endif
              sh_div <= (i_cfg_data[7:0] == 8'd0) ? 8'd1 : i_cfg_data[7:0];
          end
        endcase
      end
      if (state == WAIT && i_frame)
        fcnt <= frm_ok ? 8'd0 : fcnt + 8'd1;
      // Active registers only change on a frame boundary
      if (frm_ok) begin
        spdx    <= sh_spdx;
        spdy    <= sh_spdy;
        o_qsize <= sh_size;
        div     <= sh_div;
      end
      if (state == UPD_X) begin
        o_qx  <= a_new[CORDW-1:0];
        o_qdx <= a_ndir;
        hit_x <= a_hit;
      end
      if (state == UPD_Y) begin
        o_qy     <= a_new[CORDW-1:0];
        o_qdy    <= a_ndir;
        o_bounce <= hit_x | a_hit;
        step_q   <= 1'b0;
      end else if (i_step && !i_run && (state == IDLE || state == WAIT)) begin
        step_q <= 1'b1;
      end
    end
  end

`ifdef BOUNCE_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      o_bounce_cnt <= 16'd0;
    else if (cfg_acc && i_cfg_addr == 2'd3 && i_cfg_data[CORDW-1])
      o_bounce_cnt <= 16'd0;
    else if (o_bounce && o_bounce_cnt != 16'hFFFF)
      o_bounce_cnt <= o_bounce_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bounce_motion_ctrl.sv
// Directed bench for bounce_motion_ctrl.
// Hand-computed positions, bounces, divider and config-commit timing.
module tb_bounce_motion_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_frame = 1'b0;
  logic       i_run = 1'b0;
  logic       i_step = 1'b0;
  logic       i_cfg_valid = 1'b0;
  logic       o_cfg_ready;
  logic [1:0] i_cfg_addr = 2'd0;
  logic [9:0] i_cfg_data = 10'd0;
  logic [9:0] o_qx, o_qy, o_qsize;
  logic       o_qdx, o_qdy, o_bounce, o_busy;
`ifdef BOUNCE_CNT_EN
  logic [15:0] o_bounce_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  bounce_motion_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_frame     (i_frame),
    .i_run       (i_run),
    .i_step      (i_step),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_data  (i_cfg_data),
    .o_qx        (o_qx),
    .o_qy        (o_qy),
    .o_qsize     (o_qsize),
    .o_qdx       (o_qdx),
    .o_qdy       (o_qdy),
    .o_bounce    (o_bounce),
`ifdef BOUNCE_CNT_EN
    .o_bounce_cnt(o_bounce_cnt),
`endif
    .o_busy      (o_busy)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_run = 1'b0;
    i_step = 1'b0;
    i_frame = 1'b0;
    i_cfg_valid = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [9:0] d);
    chk("cfg_ready_pre", 32'(o_cfg_ready), 1);
    i_cfg_valid = 1'b1;
    i_cfg_addr = a;
    i_cfg_data = d;
    tick();
    i_cfg_valid = 1'b0;
  endtask

  task automatic frame_upd(input bit wr, input logic [1:0] a,
                           input logic [9:0] d, input int eqx,
                           input int eqy, input bit edx, input bit edy,
                           input bit eb);
    i_frame = 1'b1;
    i_cfg_valid = wr;
    i_cfg_addr = a;
    i_cfg_data = d;
    tick();
    i_frame = 1'b0;
    i_cfg_valid = 1'b0;
    chk("busy_ux", 32'(o_busy), 1);
    chk("ready_ux", 32'(o_cfg_ready), 0);
    tick();
    chk("ready_uy", 32'(o_cfg_ready), 0);
    chk("qx", 32'(o_qx), 32'(eqx));
    chk("qdx", 32'(o_qdx), 32'(edx));
    tick();
    chk("qy", 32'(o_qy), 32'(eqy));
    chk("qdy", 32'(o_qdy), 32'(edy));
    chk("bounce", 32'(o_bounce), 32'(eb));
    chk("busy_done", 32'(o_busy), 0);
    chk("ready_done", 32'(o_cfg_ready), 1);
    tick();
    chk("bounce_off", 32'(o_bounce), 0);
  endtask

  task automatic frame_noupd(input int eqx);
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    chk("nobusy", 32'(o_busy), 0);
    tick();
    chk("qx_hold", 32'(o_qx), 32'(eqx));
  endtask

  initial begin
    // 1: reset state and basic motion
    do_reset();
    chk("rst_qx", 32'(o_qx), 220);
    chk("rst_qy", 32'(o_qy), 140);
    chk("rst_size", 32'(o_qsize), 200);
    chk("rst_dx", 32'(o_qdx), 0);
    chk("rst_dy", 32'(o_qdy), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_ready", 32'(o_cfg_ready), 1);
    chk("rst_bounce", 32'(o_bounce), 0);
    i_run = 1'b1;
    tick();
    frame_upd(0, 2'd0, 10'd0, 222, 142, 0, 0, 0);
    frame_upd(0, 2'd0, 10'd0, 224, 144, 0, 0, 0);
    frame_upd(0, 2'd0, 10'd0, 226, 146, 0, 0, 0);

    // 2: right wall bounce with speed 50
    do_reset();
    cfg(2'd2, 10'd200);
    cfg(2'd0, 10'd50);
    i_run = 1'b1;
    tick();
    frame_upd(0, 2'd0, 10'd0, 270, 142, 0, 0, 0);
    frame_upd(0, 2'd0, 10'd0, 320, 144, 0, 0, 0);
    frame_upd(0, 2'd0, 10'd0, 370, 146, 0, 0, 0);
    frame_upd(0, 2'd0, 10'd0, 420, 148, 0, 0, 0);
    frame_upd(0, 2'd0, 10'd0, 439, 150, 1, 0, 1);
    frame_upd(0, 2'd0, 10'd0, 389, 152, 1, 0, 0);

    // 3: frame divider 3, then divider 0 acting as 1
    do_reset();
    cfg(2'd3, 10'd3);
    i_run = 1'b1;
    tick();
    frame_upd(0, 2'd0, 10'd0, 222, 142, 0, 0, 0);
    frame_noupd(222);
    frame_noupd(222);
    frame_upd(0, 2'd0, 10'd0, 224, 144, 0, 0, 0);
    frame_noupd(224);
    frame_noupd(224);
    frame_upd(0, 2'd0, 10'd0, 226, 146, 0, 0, 0);
    cfg(2'd3, 10'd0);
    frame_noupd(226);
    frame_noupd(226);
    frame_upd(0, 2'd0, 10'd0, 228, 148, 0, 0, 0);
    frame_upd(0, 2'd0, 10'd0, 230, 150, 0, 0, 0);

    // 4: write in commit cycle, size clamp, corner bounces
    do_reset();
    i_run = 1'b1;
    tick();
    frame_upd(1, 2'd0, 10'd7, 222, 142, 0, 0, 0);
    frame_upd(0, 2'd0, 10'd0, 229, 144, 0, 0, 0);
    cfg(2'd2, 10'd479);
    frame_upd(0, 2'd0, 10'd0, 161, 1, 1, 1, 1);
    chk("size_clamp", 32'(o_qsize), 478);
    frame_upd(0, 2'd0, 10'd0, 154, 0, 1, 0, 1);

    // 5: single step, then step ignored while running
    do_reset();
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    chk("step_wait_busy", 32'(o_busy), 0);
    frame_upd(0, 2'd0, 10'd0, 222, 142, 0, 0, 0);
    frame_noupd(222);
    i_run = 1'b1;
    i_step = 1'b1;
    tick();
    i_run = 1'b0;
    i_step = 1'b0;
    tick();
    frame_noupd(222);
    chk("step_qy_hold", 32'(o_qy), 142);

    // 6: reset during the Y update cycle
    do_reset();
    i_run = 1'b1;
    tick();
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    tick();
    chk("mid_qx", 32'(o_qx), 222);
    chk("mid_busy", 32'(o_busy), 1);
    i_rst_n = 1'b0;
    i_run = 1'b0;
    tick();
    chk("mrst_qx", 32'(o_qx), 220);
    chk("mrst_qy", 32'(o_qy), 140);
    chk("mrst_busy", 32'(o_busy), 0);
    chk("mrst_bounce", 32'(o_bounce), 0);
    chk("mrst_ready", 32'(o_cfg_ready), 1);
    i_rst_n = 1'b1;
    tick();
    chk("mrst_bounce2", 32'(o_bounce), 0);
    frame_noupd(220);
    chk("mrst_qy_hold", 32'(o_qy), 140);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
